// File: rtl/ninjakun_ctrl_pkg.sv
// Shared definitions for the control-panel conditioner.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
//
// Holds the panel bit map, the coin FSM state type, counter-width helpers
// and the opposing-direction (SOCD) filter used per player.
package ninjakun_ctrl_pkg;

    // Panel bit map, shared by the raw inputs and the negative-logic outputs.
    localparam int BIT_LEFT  = 0;
    localparam int BIT_RIGHT = 1;
    localparam int BIT_UP    = 2;
    localparam int BIT_DOWN  = 3;
    localparam int BIT_BTN1  = 4;
    localparam int BIT_BTN2  = 5;
    localparam int BIT_START = 6;
    localparam int BIT_COIN  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } coin_state_t;

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max_val) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Debounce counter only ever holds 0..DEBOUNCE-1.
    function automatic int dbc_cnt_w(input int debounce);
        return cnt_width(debounce - 1);
    endfunction

    // Frame counter holds 0..COIN_FRAMES.
    function automatic int frm_cnt_w(input int coin_frames);
        return cnt_width(coin_frames);
    endfunction

    // Opposing directions pressed together collapse to neither pressed.
    function automatic logic [3:0] socd_filter(input logic [3:0] dir, input logic en);
        logic [3:0] f;
        f = dir;
        if (en && dir[BIT_LEFT] && dir[BIT_RIGHT]) begin
            f[BIT_LEFT]  = 1'b0;
            f[BIT_RIGHT] = 1'b0;
        end
        if (en && dir[BIT_UP] && dir[BIT_DOWN]) begin
            f[BIT_UP]   = 1'b0;
            f[BIT_DOWN] = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/ninjakun_debounce.sv
// One-bit synchroniser + debouncer: accepts a level after DEBOUNCE stable cycles.
// Latency: 2 sync cycles + DEBOUNCE counting cycles (accept on the last one).
// Backpressure: none; free-running on INPCL.
//
// Ports: INPCL/RESET clock and async active-high reset; raw asynchronous input;
// acc accepted (debounced) level; rise one-cycle strobe in the cycle the
// accepted level is about to go 0->1 (lets a consumer react on the accept edge).
module ninjakun_debounce
    import ninjakun_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic INPCL,
    input  logic RESET,
    input  logic raw,
    output logic acc,
    output logic rise
);

    localparam int             CW       = dbc_cnt_w(DEBOUNCE);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            // Still differing on the last counted cycle: accept the new level.
            acc_d = ~acc_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge INPCL or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign rise = acc_d & ~acc_q;

endmodule

// File: rtl/ninjakun_ctrl_cond.sv
// Control-panel conditioner: sync/debounce raw controls, SOCD filter, coin pulses.
// Latency: DEBOUNCE+3 INPCL cycles raw-to-CTRn; coin pulse ends 1 cycle after the last tick.
// Backpressure: none; outputs are registered levels.
//
// Ports: INPCL clock, RESET async active-high, VBLK asynchronous vertical blank,
// P1I/P2I raw active-high controls, CTR1/CTR2 negative-logic panel bytes.
module ninjakun_ctrl_cond
    import ninjakun_ctrl_pkg::*;
#(
    parameter int DEBOUNCE     = 16,
    parameter int COIN_FRAMES  = 3,
    parameter int SOCD_NEUTRAL = 1
) (
    input  logic       INPCL,
    input  logic       RESET,
    input  logic       VBLK,
    input  logic [7:0] P1I,
    input  logic [7:0] P2I,
    output logic [7:0] CTR1,
    output logic [7:0] CTR2
);

    localparam int            FW          = frm_cnt_w(COIN_FRAMES);
    localparam logic [FW-1:0] FRAMES_INIT = FW'(COIN_FRAMES);
    localparam logic          SOCD_EN     = (SOCD_NEUTRAL != 0);

    logic [1:0][7:0] raw;
    logic [1:0][7:0] p_acc;
    logic [1:0][7:0] p_rise;
    logic            unused_rise;

    assign raw[0] = P1I;
    assign raw[1] = P2I;

    for (genvar p = 0; p < 2; p++) begin : g_player
        for (genvar i = 0; i < 8; i++) begin : g_bit
            ninjakun_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_dbc (
                .INPCL (INPCL),
                .RESET (RESET),
                .raw   (raw[p][i]),
                .acc   (p_acc[p][i]),
                .rise  (p_rise[p][i])
            );
        end
    end

    // Only the coin accept strobe drives anything; the rest are levels.
    assign unused_rise = ^{p_rise[1][6:0], p_rise[0][6:0]};

    logic               vs1_q, vs1_d;
    logic               vs2_q, vs2_d;
    logic               vprev_q, vprev_d;
    logic               tick;
    coin_state_t        state_q [2];
    coin_state_t        state_d [2];
    logic [1:0][FW-1:0] frm_q, frm_d;
    logic [1:0][7:0]    ctr_q, ctr_d;

    always_comb begin
        vs1_d   = VBLK;
        vs2_d   = vs1_q;
        vprev_d = vs2_q;
        tick    = vs2_q & ~vprev_q;

        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            frm_d[p]   = frm_q[p];
            case (state_q[p])
                IDLE: begin
                    // Load wins over a coincident tick: that tick is ignored.
                    if (p_rise[p][BIT_COIN]) begin
                        state_d[p] = PULSE;
                        frm_d[p]   = FRAMES_INIT;
                    end
                end
                PULSE: begin
                    if (tick) begin
                        if (frm_q[p] <= FW'(1)) begin
                            frm_d[p]   = '0;
                            state_d[p] = HOLD;
                        end else begin
                            frm_d[p] = frm_q[p] - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // A release-then-accept in back-to-back cycles (DEBOUNCE=1)
                    // would otherwise slip past IDLE, so start the pulse here.
                    if (p_rise[p][BIT_COIN]) begin
                        state_d[p] = PULSE;
                        frm_d[p]   = FRAMES_INIT;
                    end else if (!p_acc[p][BIT_COIN]) begin
                        state_d[p] = IDLE;
                    end
                end
                default: begin
                    state_d[p] = IDLE;
                    frm_d[p]   = '0;
                end
            endcase

            ctr_d[p] = ~{state_q[p] == PULSE,
                         p_acc[p][BIT_START:BIT_BTN1],
                         socd_filter(p_acc[p][BIT_DOWN:BIT_LEFT], SOCD_EN)};
        end
    end

    always_ff @(posedge INPCL or posedge RESET) begin
        if (RESET) begin
            vs1_q   <= 1'b0;
            vs2_q   <= 1'b0;
            vprev_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= IDLE;
                frm_q[p]   <= '0;
                ctr_q[p]   <= 8'hFF;
            end
        end else begin
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            vprev_q <= vprev_d;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                frm_q[p]   <= frm_d[p];
                ctr_q[p]   <= ctr_d[p];
            end
        end
    end

    assign CTR1 = ctr_q[0];
    assign CTR2 = ctr_q[1];

endmodule
